fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC SHALL default to 32'h8000_0000 and set the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset (asserted when 0).
REQ-004 imem_req_valid  output  1  SHALL flag an instruction read request.
REQ-005 imem_req_ready  input  1  SHALL flag that memory accepts the request this cycle.
REQ-006 imem_addr  output  32  SHALL carry the request address (word aligned).
REQ-007 imem_rsp_valid  input  1  SHALL flag valid read data.
REQ-008 imem_rsp_data  input  32  SHALL carry the returned instruction word.
REQ-009 out_valid  output  1  SHALL flag that out_pc/out_instr hold a fetched instruction.
REQ-010 out_ready  input  1  SHALL flag that the decode stage consumes the instruction.
REQ-011 out_pc  output  32  SHALL carry the PC of the held instruction.
REQ-012 out_instr  output  32  SHALL carry the held instruction.
REQ-013 redirect_valid  input  1  SHALL flag a taken branch, jump or trap from execute.
REQ-014 redirect_pc  input  32  SHALL carry the redirect target; bits [1:0] SHALL be ignored (treated as 0).

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, VALID; at most one request SHALL be outstanding.
REQ-016 IDLE SHALL go to REQ unconditionally on the first edge after reset release.
REQ-017 In REQ: imem_req_valid=1, imem_addr=pc; a handshake (req_valid & req_ready) SHALL go to WAIT.
REQ-018 In WAIT: imem_rsp_valid SHALL latch rsp_data into out_instr and pc into out_pc, then go to VALID.
REQ-019 In VALID: out_valid=1, outputs stable until out_ready; on out_ready, pc SHALL become pc+4 (mod 2^32) and the FSM SHALL go to REQ.
REQ-020 Minimum latency SHALL be: request in cycle N, handshake N, response N+1, out_valid N+2.
REQ-021 Redirect in REQ without handshake: pc<=redirect_pc, stay REQ; imem_addr SHALL show the new target next cycle.
REQ-022 Redirect in REQ with handshake, or in WAIT: pc<=redirect_pc, a drop flag SHALL be set; the response is discarded and the FSM goes to REQ.
REQ-023 Redirect coincident with imem_rsp_valid in WAIT: the response SHALL be discarded, pc<=redirect_pc, next state REQ.
REQ-024 Redirect in VALID (with or without out_ready): out_valid SHALL drop next cycle, pc<=redirect_pc, next state REQ; redirect overrides pc+4.
REQ-025 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-026 imem_req_valid SHALL be 0 in IDLE, WAIT, VALID; out_valid SHALL be 0 outside VALID.

Reset
REQ-027 Reset SHALL force: state=IDLE, pc=RESET_PC, drop=0, imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0 (32'h0000_0000).
REQ-028 Reset asserted mid-operation SHALL abandon any outstanding request; its late response SHALL be ignored per REQ-025.

Structure
REQ-029 The FSM state enum (FetchState) and RESET_PC default SHALL live in the shared common package/header.
REQ-030 The block SHALL be a single module with no sub-modules; PC, drop flag and output registers are local.

Verification
REQ-031 Reset release, req_ready=1, 1-cycle rsp 32'h0000_0413 -> imem_addr=0x8000_0000, out_valid at cycle 2, out_pc=0x8000_0000.
REQ-032 out_ready held 0 for 5 cycles then 1 -> out_pc/out_instr stable, next imem_addr=0x8000_0004.
REQ-033 Redirect to 0x8000_0100 in WAIT; stale rsp 32'hDEAD_BEEF -> DEAD_BEEF never on out_instr; next imem_addr=0x8000_0100.
REQ-034 req_ready=0 for 3 cycles, redirect 0x8000_0203 meanwhile -> imem_addr switches to 0x8000_0200, request stays asserted.
REQ-035 Redirect + out_ready same cycle in VALID, pc=0xFFFF_FFFC -> next fetch at redirect_pc; without redirect, wrap to 0x0000_0000.
REQ-036 rst low during WAIT, rsp arrives in IDLE -> ignored, fetch restarts at 0x8000_0000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } FetchState;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: instruction memory port, decode handoff, redirect.
interface fetch_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with redirect handling.
//   state | meaning
//   IDLE  | one cycle after reset release, before the first request
//   REQ   | request presented at pc, waiting for memory to accept
//   WAIT  | request accepted, waiting for the response (dropped if drop set)
//   VALID | fetched instruction held for decode
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);

  FetchState   state;
  logic [31:0] pc;
  logic        drop;
  logic        req_valid_q;
  logic        out_valid_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_instr_q;

  logic        handshake;
  logic        redirect;
  logic [31:0] redirect_target;

  assign handshake       = req_valid_q & bus.imem_req_ready;
  assign redirect        = bus.redirect_valid;
  assign redirect_target = word_align(bus.redirect_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0000_0000;
      out_instr_q <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          state       <= REQ;
          req_valid_q <= 1'b1;
          if (redirect) pc <= redirect_target;
        end
        REQ: begin
          if (handshake) begin
            state       <= WAIT;
            req_valid_q <= 1'b0;
            if (redirect) begin
              pc   <= redirect_target;
              drop <= 1'b1;
            end
          end else if (redirect) begin
            pc <= redirect_target;
          end
        end
        WAIT: begin
          // A redirected fetch still waits for its response so that only one
          // request is ever in flight; the response is then thrown away.
          if (bus.imem_rsp_valid) begin
            drop <= 1'b0;
            if (redirect) begin
              pc          <= redirect_target;
              state       <= REQ;
              req_valid_q <= 1'b1;
            end else if (drop) begin
              state       <= REQ;
              req_valid_q <= 1'b1;
            end else begin
              out_pc_q    <= pc;
              out_instr_q <= bus.imem_rsp_data;
              out_valid_q <= 1'b1;
              state       <= VALID;
            end
          end else if (redirect) begin
            pc   <= redirect_target;
            drop <= 1'b1;
          end
        end
        VALID: begin
          if (redirect || bus.out_ready) begin
            out_valid_q <= 1'b0;
            req_valid_q <= 1'b1;
            state       <= REQ;
            pc          <= redirect ? redirect_target : pc + 32'd4;
          end
        end
        default: begin
          state       <= IDLE;
          req_valid_q <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = pc;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_instr      = out_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: handshakes, stalls, redirects, wrap, reset.
module tb_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    tick(); tick();
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc: got %h expected 0", bus.out_pc); end
    n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %h expected 0", bus.out_instr); end
    n_cmp++; if (bus.imem_addr !== 32'h8000_0000) begin n_err++; $display("FAIL reset_addr: got %h expected 80000000", bus.imem_addr); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid: got %b expected 1", bus.imem_req_valid); end
  endtask

  task automatic test_basic_fetch;
    bus.imem_req_ready = 1'b1;
    n_cmp++; if (bus.imem_addr !== 32'h8000_0000) begin n_err++; $display("FAIL basic_addr: got %h expected 80000000", bus.imem_addr); end
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0413;
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait_req: got %b expected 0", bus.imem_req_valid); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait_out: got %b expected 0", bus.out_valid); end
    tick();
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h1111_1111;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %b expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_pc !== 32'h8000_0000) begin n_err++; $display("FAIL basic_out_pc: got %h expected 80000000", bus.out_pc); end
    n_cmp++; if (bus.out_instr !== 32'h0000_0413) begin n_err++; $display("FAIL basic_out_instr: got %h expected 00000413", bus.out_instr); end
  endtask

  task automatic test_decode_stall;
    bus.out_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;  // stray response while not waiting must be ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0000 || bus.out_instr !== 32'h0000_0413 || bus.imem_req_valid !== 1'b0)
        begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h req=%b expected 1/80000000/00000413/0", i, bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_req_valid); end
    end
    bus.imem_rsp_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'h8000_0004) begin n_err++; $display("FAIL stall_next_addr: got %h expected 80000004", bus.imem_addr); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_out_drop: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_req: got %b expected 1", bus.imem_req_valid); end
  endtask

  task automatic test_redirect_wait;
    bus.imem_req_ready = 1'b1;
    tick();  // handshake at 80000004, now WAIT
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdw_no_second_req: got %b expected 0", bus.imem_req_valid); end
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rdw_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0000_0413) begin n_err++; $display("FAIL rdw_stale_instr: got %h expected 00000413", bus.out_instr); end
    n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0100) begin n_err++; $display("FAIL rdw_next_addr: got req=%b addr=%h expected 1/80000100", bus.imem_req_valid, bus.imem_addr); end
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0010_0093;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0100 || bus.out_instr !== 32'h0010_0093)
      begin n_err++; $display("FAIL rdw_refetch: got v=%b pc=%h instr=%h expected 1/80000100/00100093", bus.out_valid, bus.out_pc, bus.out_instr); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_ready_stall_redirect;
    bus.imem_req_ready = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'h8000_0104) begin n_err++; $display("FAIL rs_start_addr: got %h expected 80000104", bus.imem_addr); end
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0203;
    tick();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'h8000_0200 || bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rs_switch: got addr=%h req=%b expected 80000200/1", bus.imem_addr, bus.imem_req_valid); end
    tick();
    n_cmp++; if (bus.imem_addr !== 32'h8000_0200 || bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rs_hold: got addr=%h req=%b expected 80000200/1", bus.imem_addr, bus.imem_req_valid); end
    // redirect on the handshake cycle: response must be discarded
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0300;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0BAD_0BAD;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0300)
      begin n_err++; $display("FAIL rs_hs_redirect: got v=%b req=%b addr=%h expected 0/1/80000300", bus.out_valid, bus.imem_req_valid, bus.imem_addr); end
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0300 || bus.out_instr !== 32'h0000_0013)
      begin n_err++; $display("FAIL rs_refetch: got v=%b pc=%h instr=%h expected 1/80000300/00000013", bus.out_valid, bus.out_pc, bus.out_instr); end
  endtask

  task automatic test_wrap;
    // in VALID: redirect + out_ready together, redirect wins over pc+4
    bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_redir1: got addr=%h v=%b expected fffffffc/0", bus.imem_addr, bus.out_valid); end
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_valid: got v=%b pc=%h expected 1/fffffffc", bus.out_valid, bus.out_pc); end
    bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0040;
    tick();
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'h8000_0040 || bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL wrap_redir2: got addr=%h req=%b expected 80000040/1", bus.imem_addr, bus.imem_req_valid); end
    tick();
    // redirect coincident with response in WAIT
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    tick();
    bus.imem_rsp_valid = 1'b0; bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0000_0013 || bus.imem_addr !== 32'hFFFF_FFFC)
      begin n_err++; $display("FAIL wrap_coincident: got v=%b instr=%h addr=%h expected 0/00000013/fffffffc", bus.out_valid, bus.out_instr, bus.imem_addr); end
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0093;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'h0000_0000 || bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL wrap_zero: got addr=%h req=%b expected 00000000/1", bus.imem_addr, bus.imem_req_valid); end
  endtask

  task automatic test_reset_mid;
    tick();  // handshake at 00000000, now WAIT
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.imem_addr !== 32'h8000_0000 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.imem_req_valid !== 1'b0)
      begin n_err++; $display("FAIL mid_reset_async: got addr=%h v=%b pc=%h req=%b expected 80000000/0/0/0", bus.imem_addr, bus.out_valid, bus.out_pc, bus.imem_req_valid); end
    tick();
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8000_0000)
      begin n_err++; $display("FAIL mid_late_rsp: got v=%b instr=%h req=%b addr=%h expected 0/0/1/80000000", bus.out_valid, bus.out_instr, bus.imem_req_valid, bus.imem_addr); end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0000 || bus.out_instr !== 32'h0000_0013)
      begin n_err++; $display("FAIL mid_restart: got v=%b pc=%h instr=%h expected 1/80000000/00000013", bus.out_valid, bus.out_pc, bus.out_instr); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic_fetch();
    test_decode_stall();
    test_redirect_wait();
    test_ready_stall_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
